// File: rtl/b01_serial_arbiter_if.sv
// b01_serial_arbiter_if: request/operand, serial unit and result signals for b01_serial_arbiter
interface b01_serial_arbiter_if #(
   parameter int WIDTH = 8
);
   logic req0, req1;
   logic [WIDTH-1:0] a0, b0, a1, b1;
   logic gnt0, gnt1;
   logic LINE1, LINE2, unit_clr, unit_outp, unit_ovf;
   logic [WIDTH-1:0] result;
   logic ovf_flag, done, done_id, busy;
   modport master (
      output req0, req1, a0, b0, a1, b1, unit_outp, unit_ovf,
      input gnt0, gnt1, LINE1, LINE2, unit_clr, result, ovf_flag, done, done_id, busy
   );
   modport slave (
      input req0, req1, a0, b0, a1, b1, unit_outp, unit_ovf,
      output gnt0, gnt1, LINE1, LINE2, unit_clr, result, ovf_flag, done, done_id, busy
   );
endinterface

// File: rtl/b01_serial_arbiter.sv
// b01_serial_arbiter: round-robin sharing of one b01 serial unit; B01_ARB_OVF_ABORT_EN ends a job on the first captured overflow
module b01_serial_arbiter #(
   parameter int WIDTH = 8
) (
   input logic clock,
   input logic RESET_G,
   b01_serial_arbiter_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] a_sr, b_sr, cap, cap_nxt;
   logic [CW-1:0] cnt, cap_idx;
   logic ovf_acc, ovf_nxt, id, last, pick, cap_en, fin;
   // unit output lags the lines by one cycle, so bit k lands two shift cycles after it is driven
   always_comb begin
      pick = (bus.req0 && bus.req1) ? ~last : bus.req1;
      cap_en = (state == SHIFT && cnt >= CW'(2)) || state == DRAIN || state == DONE;
      cap_idx = state == SHIFT ? cnt - CW'(2) : state == DRAIN ? CW'(WIDTH - 2) : CW'(WIDTH - 1);
      cap_nxt = cap | (WIDTH'(bus.unit_outp) << cap_idx);
      ovf_nxt = ovf_acc | bus.unit_ovf;
`ifdef B01_ARB_OVF_ABORT_EN
      fin = state == DONE || (cap_en && bus.unit_ovf);
`else
      fin = state == DONE;
`endif
   end
   always_ff @(posedge clock or posedge RESET_G)
      if (RESET_G) begin
         state <= IDLE;
         bus.gnt0 <= 1'b0;
         bus.gnt1 <= 1'b0;
         bus.LINE1 <= 1'b0;
         bus.LINE2 <= 1'b0;
         bus.unit_clr <= 1'b0;
         bus.result <= '0;
         bus.ovf_flag <= 1'b0;
         bus.done <= 1'b0;
         bus.done_id <= 1'b0;
         bus.busy <= 1'b0;
         a_sr <= '0;
         b_sr <= '0;
         cap <= '0;
         cnt <= '0;
         ovf_acc <= 1'b0;
         id <= 1'b0;
         last <= 1'b1;
      end else begin
         bus.gnt0 <= 1'b0;
         bus.gnt1 <= 1'b0;
         bus.unit_clr <= 1'b0;
         bus.done <= 1'b0;
         if (cap_en) begin
            cap <= cap_nxt;
            ovf_acc <= ovf_nxt;
         end
         case (state)
            IDLE: if (bus.req0 || bus.req1) begin
               bus.gnt0 <= ~pick;
               bus.gnt1 <= pick;
               a_sr <= pick ? bus.a1 : bus.a0;
               b_sr <= pick ? bus.b1 : bus.b0;
               id <= pick;
               bus.busy <= 1'b1;
               state <= CLR;
            end
            CLR: begin
               bus.unit_clr <= 1'b1;
               bus.LINE1 <= 1'b0;
               bus.LINE2 <= 1'b0;
               cnt <= '0;
               cap <= '0;
               ovf_acc <= 1'b0;
               state <= SHIFT;
            end
            SHIFT: begin
               bus.LINE1 <= a_sr[0];
               bus.LINE2 <= b_sr[0];
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) state <= DRAIN;
            end
            DRAIN: begin
               bus.LINE1 <= 1'b0;
               bus.LINE2 <= 1'b0;
               state <= DONE;
            end
            default: ;
         endcase
         if (fin) begin
            bus.result <= cap_nxt;
            bus.ovf_flag <= ovf_nxt;
            bus.done <= 1'b1;
            bus.done_id <= id;
            bus.busy <= 1'b0;
            bus.LINE1 <= 1'b0;
            bus.LINE2 <= 1'b0;
            last <= id;
            state <= IDLE;
         end
      end
endmodule

// File: tb/tb_b01_serial_arbiter.sv
// tb_b01_serial_arbiter: directed and random checks of b01_serial_arbiter against a job-level model and a stub serial unit
module tb_b01_serial_arbiter;
   localparam int W = 8;
   logic clock = 1'b0;
   logic RESET_G;
   always #5 clock = ~clock;
   b01_serial_arbiter_if #(.WIDTH(W)) bus();
   b01_serial_arbiter #(.WIDTH(W)) dut (.clock(clock), .RESET_G(RESET_G), .bus(bus));
   always_ff @(posedge clock or posedge RESET_G)
      if (RESET_G) begin
         bus.unit_outp <= 1'b0;
         bus.unit_ovf <= 1'b0;
      end else if (bus.unit_clr) begin
         bus.unit_outp <= 1'b0;
         bus.unit_ovf <= 1'b0;
      end else begin
         bus.unit_outp <= bus.LINE1 ^ bus.LINE2;
         bus.unit_ovf <= bus.LINE1 & bus.LINE2;
      end
   int total = 0, bad = 0, cyc = 0, tg = 0, td = 0, n_g0 = 0;
   int p = -1, len = 0;
   logic jid, jovf, last_m;
   logic [W-1:0] ja, jb, jres;
   logic e_g0, e_g1, e_done, e_busy, e_clr, e_l1, e_l2, e_ovf, e_id;
   logic [W-1:0] e_res;
   bit hold1 = 0;
   logic dut_ids[$];
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask
   // a job's result is a^b bit by bit; overflow is any position where both operands are 1
   task automatic plan(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] c;
      c = a & b;
      jres = a ^ b;
      jovf = |c;
      len = W + 3;
`ifdef B01_ARB_OVF_ABORT_EN
      for (int i = W - 1; i >= 0; i--)
         if (c[i]) begin
            len = 4 + i;
            jres = (a ^ b) & W'((64'd1 << (i + 1)) - 64'd1);
         end
`endif
   endtask
   task automatic advance();
      if (p < 0 || p >= len) begin
         if (bus.req0 || bus.req1) begin
            jid = (bus.req0 && bus.req1) ? !last_m : bus.req1;
            ja = jid ? bus.a1 : bus.a0;
            jb = jid ? bus.b1 : bus.b0;
            plan(ja, jb);
            p = 0;
         end else p = -1;
      end else p++;
      e_g0 = p == 0 && !jid;
      e_g1 = p == 0 && jid;
      e_done = p >= 0 && p == len;
      e_busy = p >= 0 && p < len;
      e_clr = p == 1;
      e_l1 = 1'b0;
      e_l2 = 1'b0;
      if (p >= 2 && p <= W + 1 && p < len) begin
         e_l1 = ja[p-2];
         e_l2 = jb[p-2];
      end
      if (e_done) begin
         e_res = jres;
         e_ovf = jovf;
         e_id = jid;
         last_m = jid;
      end
   endtask
   task automatic check_all();
      chk("gnt0", bus.gnt0, e_g0);
      chk("gnt1", bus.gnt1, e_g1);
      chk("done", bus.done, e_done);
      chk("busy", bus.busy, e_busy);
      chk("unit_clr", bus.unit_clr, e_clr);
      chk("line1", bus.LINE1, e_l1);
      chk("line2", bus.LINE2, e_l2);
      chk("result", bus.result, e_res);
      chk("ovf_flag", bus.ovf_flag, e_ovf);
      chk("done_id", bus.done_id, e_id);
   endtask
   task automatic tick();
      advance();
      @(posedge clock);
      #1;
      cyc++;
      check_all();
      if (bus.gnt0 || bus.gnt1) tg = cyc;
      if (bus.gnt0) n_g0++;
      if (bus.done) begin
         td = cyc;
         dut_ids.push_back(bus.done_id);
      end
      if (e_g0) bus.req0 = 1'b0;
      if (e_g1 && !hold1) bus.req1 = 1'b0;
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic do_reset();
      RESET_G = 1'b1;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      #1;
      p = -1;
      last_m = 1'b1;
      {e_g0, e_g1, e_done, e_busy, e_clr, e_l1, e_l2, e_ovf, e_id} = '0;
      e_res = '0;
      check_all();
      @(posedge clock);
      #1;
      RESET_G = 1'b0;
   endtask
   task automatic raise(input bit r);
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = $urandom_range(0, 1) ? W'($urandom) & ~a : W'($urandom);
      if (r) begin
         bus.a1 = a;
         bus.b1 = b;
         bus.req1 = 1'b1;
      end else begin
         bus.a0 = a;
         bus.b0 = b;
         bus.req0 = 1'b1;
      end
   endtask
   initial begin
      {bus.a0, bus.b0, bus.a1, bus.b1} = '0;
      do_reset();
      bus.a0 = 8'h0F;
      bus.b0 = 8'hF0;
      bus.req0 = 1'b1;
      run(20);
      chk("t1_latency", td - tg, 11);
      chk("t1_result", bus.result, 8'hFF);
      chk("t1_ovf", bus.ovf_flag, 0);
      chk("t1_id", bus.done_id, 0);
      do_reset();
      dut_ids.delete();
      raise(0);
      raise(1);
      run(30);
      chk("t2_jobs", dut_ids.size(), 2);
      chk("t2_first", dut_ids[0], 0);
      chk("t2_second", dut_ids[1], 1);
      dut_ids.delete();
      hold1 = 1;
      raise(1);
      for (int k = 0; k < 50; k++) begin
         if (!bus.req0) raise(0);
         tick();
      end
      hold1 = 0;
      bus.req1 = 1'b0;
      run(40);
      chk("t3_jobs", dut_ids.size() >= 4, 1);
      for (int k = 0; k < 4; k++) chk("t3_alternate", dut_ids[k], k % 2);
      bus.a1 = 8'h81;
      bus.b1 = 8'h01;
      bus.req1 = 1'b1;
      run(20);
      chk("t4_ovf", bus.ovf_flag, 1);
      chk("t4_id", bus.done_id, 1);
`ifdef B01_ARB_OVF_ABORT_EN
      chk("t4_latency", td - tg, 4);
      chk("t4_result", bus.result, 8'h00);
`else
      chk("t4_latency", td - tg, 11);
      chk("t4_result", bus.result, 8'h80);
`endif
      raise(0);
      for (int k = 0; k < 20 && p != 5; k++) tick();
      chk("t5_busy_before", bus.busy, 1);
      dut_ids.delete();
      do_reset();
      raise(0);
      raise(1);
      run(30);
      chk("t5_jobs", dut_ids.size(), 2);
      chk("t5_first", dut_ids[0], 0);
      dut_ids.delete();
      raise(1);
      run(3);
      n_g0 = 0;
      raise(0);
      run(4);
      bus.req0 = 1'b0;
      run(20);
      chk("t6_no_gnt0", n_g0, 0);
      chk("t6_jobs", dut_ids.size(), 1);
      for (int k = 0; k < 3000; k++) begin
         if (!bus.req0) begin
            if ($urandom_range(0, 3) == 0) raise(0);
         end else if ($urandom_range(0, 49) == 0) bus.req0 = 1'b0;
         if (!bus.req1) begin
            if ($urandom_range(0, 3) == 0) raise(1);
         end else if ($urandom_range(0, 49) == 0) bus.req1 = 1'b0;
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
